// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: freezes fetch, drains the pipe, pushes PC/CCR to the stack and vectors IF
module interrupt_sequencer #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] VECTOR_PC    = 32'h0000_0000,
  parameter int          CCR_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             interrupt,
  input  logic             cu_busy,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      if_pc,
  input  logic [CCR_W-1:0] ccr_in,
  input  logic             push_ready,
  output logic             fetch_hold,
  output logic             bubble,
  output logic             push_valid,
  output logic [15:0]      push_data,
  output logic [1:0]       push_sel,
  output logic             pc_load,
  output logic [31:0]      pc_load_value,
  output logic             int_active,
  output logic             int_ack
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_H, PUSH_L, PUSH_C, VEC} state_t;
  state_t           state_q, state_d;
  logic             pending_q, pending_d, irq_q, accept;
  logic [CW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [31:0]      resume_pc_q, resume_pc_d;
  logic [CCR_W-1:0] saved_ccr_q, saved_ccr_d;
  always_comb begin
    accept      = state_q == IDLE && pending_q && !cu_busy;
    pending_d   = (interrupt && !irq_q) || (pending_q && !accept);
    resume_pc_d = accept ? (id_valid ? id_pc : if_pc) : resume_pc_q;
    saved_ccr_d = accept ? ccr_in : saved_ccr_q;
    drain_cnt_d = state_q == DRAIN ? drain_cnt_q + CW'(1) : '0;
    state_d     = state_q;
    case (state_q)
      IDLE:    state_d = accept ? DRAIN : IDLE;
      DRAIN:   state_d = drain_cnt_q == CW'(DRAIN_CYCLES - 1) ? PUSH_H : DRAIN;
      PUSH_H:  state_d = push_ready ? PUSH_L : PUSH_H;
      PUSH_L:  state_d = push_ready ? PUSH_C : PUSH_L;
      PUSH_C:  state_d = push_ready ? VEC : PUSH_C;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      irq_q       <= 1'b0;
      drain_cnt_q <= '0;
      resume_pc_q <= '0;
      saved_ccr_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      irq_q       <= interrupt;
      drain_cnt_q <= drain_cnt_d;
      resume_pc_q <= resume_pc_d;
      saved_ccr_q <= saved_ccr_d;
    end
  end
  assign int_active    = state_q != IDLE;
  assign fetch_hold    = int_active && state_q != VEC;
  assign bubble        = int_active;
  assign push_valid    = state_q inside {PUSH_H, PUSH_L, PUSH_C};
  assign push_sel      = state_q == PUSH_L ? 2'b01 : state_q == PUSH_C ? 2'b10 : 2'b00;
  assign push_data     = state_q == PUSH_H ? resume_pc_q[31:16] :
                         state_q == PUSH_L ? resume_pc_q[15:0] :
                         state_q == PUSH_C ? 16'(saved_ccr_q) : '0;
  assign pc_load       = state_q == VEC;
  assign int_ack       = state_q == VEC;
  assign pc_load_value = VECTOR_PC;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed scoreboard bench for interrupt_sequencer
module tb_interrupt_sequencer;
  logic        clk = 1'b0;
  logic        rst, interrupt, cu_busy, id_valid, push_ready;
  logic [31:0] id_pc, if_pc;
  logic [2:0]  ccr_in;
  logic        fetch_hold, bubble, push_valid, pc_load, int_active, int_ack;
  logic [15:0] push_data;
  logic [1:0]  push_sel;
  logic [31:0] pc_load_value;
  logic [17:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .cu_busy(cu_busy),
    .id_valid(id_valid), .id_pc(id_pc), .if_pc(if_pc), .ccr_in(ccr_in),
    .push_ready(push_ready), .fetch_hold(fetch_hold), .bubble(bubble),
    .push_valid(push_valid), .push_data(push_data), .push_sel(push_sel),
    .pc_load(pc_load), .pc_load_value(pc_load_value),
    .int_active(int_active), .int_ack(int_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [17:0] e;
    if (push_valid && push_ready && !rst) begin
      if (exp_q.size() == 0) chk("sb_extra_push", 32'(push_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_push", {14'd0, push_sel, push_data}, {14'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic expect_seq(input logic [31:0] pc, input logic [2:0] ccr);
    exp_q.push_back({2'b00, pc[31:16]});
    exp_q.push_back({2'b01, pc[15:0]});
    exp_q.push_back({2'b10, 13'd0, ccr});
  endtask
  task automatic pulse();
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
  endtask
  task automatic wait_vec(input string tag);
    int n = 0;
    while (!pc_load && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_vec"}, {28'd0, pc_load, int_ack, fetch_hold, bubble}, 32'hD);
    chk({tag, "_vec_pc"}, pc_load_value, 32'h0);
    tick();
    chk({tag, "_idle"}, {28'd0, int_active, int_ack, pc_load, push_valid}, 32'h0);
  endtask
  task automatic wait_push(input logic [1:0] sel);
    int n = 0;
    while (!(push_valid && push_sel == sel) && n < 40) begin
      tick();
      n++;
    end
  endtask
  initial begin
    rst = 1'b1; interrupt = 1'b0; cu_busy = 1'b0; id_valid = 1'b1;
    id_pc = 32'h0000_1234; if_pc = 32'h0000_4000; ccr_in = 3'b101; push_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ctl", {26'd0, fetch_hold, bubble, push_valid, pc_load, int_active, int_ack}, 32'h0);
    chk("reset_data", {14'd0, push_sel, push_data}, 32'h0);
    chk("reset_vecpc", pc_load_value, 32'h0);
    expect_seq(32'h0000_1234, 3'b101);
    pulse();
    chk("t1_pending_idle", 32'(int_active), 32'd0);
    tick();
    chk("t1_drain", {28'd0, int_active, fetch_hold, bubble, push_valid}, 32'hE);
    tick();
    tick();
    chk("t1_drain_end", {28'd0, int_active, fetch_hold, bubble, push_valid}, 32'hE);
    tick();
    chk("t1_push_h", {13'd0, push_valid, push_sel, push_data}, {13'd0, 1'b1, 2'b00, 16'h0000});
    tick();
    tick();
    tick();
    chk("t1_latency", {30'd0, pc_load, int_ack}, 32'h3);
    wait_vec("t1");
    chk("t1_sb_empty", exp_q.size(), 32'd0);
    expect_seq(32'h0000_1234, 3'b011);
    ccr_in = 3'b011;
    pulse();
    wait_push(2'b01);
    push_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold", {13'd0, push_valid, push_sel, push_data}, {13'd0, 1'b1, 2'b01, 16'h1234});
      tick();
    end
    push_ready = 1'b1;
    wait_vec("t2");
    chk("t2_sb_empty", exp_q.size(), 32'd0);
    expect_seq(32'h0000_1234, 3'b011);
    cu_busy = 1'b1;
    pulse();
    for (int i = 0; i < 4; i++) begin
      chk("t3_busy_idle", 32'(int_active), 32'd0);
      tick();
    end
    cu_busy = 1'b0;
    chk("t3_still_idle", 32'(int_active), 32'd0);
    tick();
    chk("t3_drain_start", {30'd0, int_active, fetch_hold}, 32'h3);
    wait_vec("t3");
    chk("t3_sb_empty", exp_q.size(), 32'd0);
    id_pc = 32'h00AB_CDEF;
    expect_seq(32'h00AB_CDEF, 3'b011);
    expect_seq(32'h00AB_CDEF, 3'b011);
    pulse();
    wait_push(2'b00);
    pulse();
    tick();
    pulse();
    wait_vec("t4a");
    tick();
    chk("t4_restart", 32'(int_active), 32'd1);
    wait_vec("t4b");
    for (int i = 0; i < 8; i++) tick();
    chk("t4_no_third", 32'(int_active), 32'd0);
    chk("t4_sb_empty", exp_q.size(), 32'd0);
    expect_seq(32'h0000_1234, 3'b011);
    id_pc = 32'h0000_1234;
    pulse();
    wait_push(2'b01);
    push_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_ready = 1'b1;
    exp_q.delete();
    chk("t5_reset_ctl", {26'd0, fetch_hold, bubble, push_valid, pc_load, int_active, int_ack}, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_no_pending", {30'd0, int_active, push_valid}, 32'h0);
    id_valid = 1'b0;
    id_pc = 32'hDEAD_BEEF;
    if_pc = 32'h0001_0000;
    ccr_in = 3'b010;
    expect_seq(32'h0001_0000, 3'b010);
    pulse();
    wait_vec("t6");
    chk("t6_sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
